// File: rtl/mul_div_unit.sv
// Multi-cycle signed/unsigned multiply and restoring divide for the HI/LO path.
// One result bit per cycle; start/busy/done handshake for control-unit stalls.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dz
);

    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]         r_state;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_dvsr;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_dz;

    logic               w_signed;
    logic               w_is_div;
    logic               w_neg_a;
    logic               w_neg_b;
    logic               w_neg_res;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic               w_dz;

    assign w_signed  = ~r_op[0];
    assign w_is_div  = r_op[1];
    assign w_neg_a   = w_signed & r_a[WIDTH-1];
    assign w_neg_b   = w_signed & r_b[WIDTH-1];
    assign w_neg_res = w_neg_a ^ w_neg_b;

    // Negating MIN wraps back to 2^(WIDTH-1), which is the correct unsigned magnitude.
    assign w_abs_a = w_neg_a ? -r_a : r_a;
    assign w_abs_b = w_neg_b ? -r_b : r_b;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_dvsr : '0)};
    assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend bits shifting out / quotient bits shifting in}.
    assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_dvsr};
    assign w_ge       = (w_rem_sh >= {1'b0, r_dvsr});
    assign w_div_next = {(w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_ge};

    assign w_prod_fix = w_neg_res ? -r_acc : r_acc;
    assign w_quo_fix  = w_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_fix  = w_neg_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_dz       = w_is_div & (r_b == '0);

    always_ff @(posedge Clock) begin
        if (!clear_n) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_dvsr  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_op    <= op;
                        r_a     <= a;
                        r_b     <= b;
                        r_state <= S_PREP;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_PREP: begin
                    r_dvsr  <= w_is_div ? w_abs_b : w_abs_a;
                    r_acc   <= {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
                    r_cnt   <= CW'(WIDTH - 1);
                    r_state <= S_CALC;
                end
                S_CALC: begin
                    r_acc <= w_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (w_dz) begin
                        r_hi <= r_a;
                        r_lo <= '1;
                    end else if (w_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                    r_dz    <= w_dz;
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state == S_PREP) | (r_state == S_CALC) | (r_state == S_FIX);
    assign done = (r_state == S_DONE);
    assign hi   = r_hi;
    assign lo   = r_lo;
    assign dz   = r_dz;

endmodule
